// File: rtl/pwm_dac_ctrl.sv
// PWM DAC controller: sample FIFO feeding a free-running PWM period counter.
// Samples are popped at period boundaries; an empty FIFO in RUN flags underrun.
module pwm_dac_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     clr_underrun,
  output logic [WIDTH-1:0]         dac_data,
  output logic [WIDTH-1:0]         pwm_cnt,
  output logic                     frame_tick,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [WIDTH-1:0] MID  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LW-1:0]    FULL = LW'(DEPTH);
  localparam logic [LW-1:0]    HALF = LW'(DEPTH / 2);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic             und_q, und_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic tick;
  logic push;
  logic pop;

  assign tick     = (state_q != IDLE) && (cnt_q == '1);
  assign in_ready = (state_q != IDLE) && (lvl_q != FULL);
  assign push     = en && in_valid && in_ready;

  assign dac_data   = dac_q;
  assign pwm_cnt    = cnt_q;
  assign frame_tick = tick;
  assign underrun   = und_q;
  assign fifo_level = lvl_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dac_d   = dac_q;
    und_d   = und_q;
    pop     = 1'b0;
    if (clr_underrun) und_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      dac_d   = MID;
    end else begin
      unique case (state_q)
        IDLE: state_d = PRIME;
        PRIME: begin
          cnt_d = cnt_q + WIDTH'(1);
          // Wait for a half-full FIFO before starting playback
          if (tick && (lvl_q >= HALF)) begin
            pop     = 1'b1;
            dac_d   = mem[rp_q];
            state_d = RUN;
          end
        end
        RUN: begin
          cnt_d = cnt_q + WIDTH'(1);
          if (tick) begin
            if (lvl_q != '0) begin
              pop   = 1'b1;
              dac_d = mem[rp_q];
            end else begin
              dac_d   = MID;
              und_d   = 1'b1;
              state_d = PRIME;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q;
    if (!en) begin
      wp_d  = '0;
      rp_d  = '0;
      lvl_d = '0;
    end else begin
      wp_d  = wp_q + AW'(push);
      rp_d  = rp_q + AW'(pop);
      lvl_d = lvl_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dac_q   <= MID;
      und_q   <= 1'b0;
      lvl_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dac_q   <= dac_d;
      und_q   <= und_d;
      lvl_q   <= lvl_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= in_data;
  end

endmodule

// File: tb/tb_pwm_dac_ctrl.sv
// Bench for pwm_dac_ctrl (WIDTH=8, DEPTH=4): priming table,
// scoreboard of played samples, underrun, enable and reset sequences.
module tb_pwm_dac_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       clr_underrun;
  logic [7:0] dac_data;
  logic [7:0] pwm_cnt;
  logic       frame_tick;
  logic       underrun;
  logic [2:0] fifo_level;

  pwm_dac_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .clr_underrun (clr_underrun),
    .dac_data     (dac_data),
    .pwm_cnt      (pwm_cnt),
    .frame_tick   (frame_tick),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         n;
    logic [2:0] lvl_pre;
    logic       rdy_pre;
    logic [7:0] dac;
    logic [2:0] lvl;
    logic       rdy;
  } vec_t;

  vec_t tbl [6];

  logic [7:0] sbq [$];
  logic       mon_en;
  logic       ft_seen;
  logic [7:0] sb_exp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input int max);
    int k;
    k = 0;
    while (!frame_tick && k < max) begin
      cyc(1);
      k++;
    end
    chk("tick_seen", frame_tick, 1'b1);
  endtask

  task automatic push1(input logic [7:0] d, input bit sb);
    in_valid = 1'b1;
    in_data  = d;
    cyc(1);
    in_valid = 1'b0;
    if (sb) sbq.push_back(d);
  endtask

  // Played-sample scoreboard: after each period end, dac_data must be
  // the oldest queued sample, or MID when nothing is queued.
  always begin
    @(posedge clk);
    #1;
    if (mon_en && ft_seen) begin
      sb_exp = (sbq.size() != 0) ? sbq.pop_front() : 8'h80;
      chk("sb_dac", dac_data, sb_exp);
    end
    ft_seen = frame_tick;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
    clr_underrun = 1'b0; mon_en = 1'b0; ft_seen = 1'b0;

    tbl[0] = '{0, 3'd0, 1'b1, 8'h80, 3'd0, 1'b1};
    tbl[1] = '{1, 3'd1, 1'b1, 8'h80, 3'd1, 1'b1};
    tbl[2] = '{2, 3'd2, 1'b1, 8'h11, 3'd1, 1'b1};
    tbl[3] = '{3, 3'd3, 1'b1, 8'h11, 3'd2, 1'b1};
    tbl[4] = '{4, 3'd4, 1'b0, 8'h11, 3'd3, 1'b1};
    tbl[5] = '{5, 3'd4, 1'b0, 8'h11, 3'd3, 1'b1};

    cyc(2);
    chk("rst_dac", dac_data, 8'h80);
    chk("rst_cnt", pwm_cnt, 8'h00);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_und", underrun, 1'b0);
    chk("rst_lvl", fifo_level, 3'd0);
    chk("rst_rdy", in_ready, 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("idle_rdy", in_ready, 1'b0);
    chk("idle_cnt", pwm_cnt, 8'h00);

    // Free-running with no data
    en = 1'b1;
    cyc(1);
    chk("prime_cnt0", pwm_cnt, 8'h00);
    chk("prime_rdy", in_ready, 1'b1);
    wait_tick(300);
    chk("tick_cnt", pwm_cnt, 8'hFF);
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (!frame_tick && k < 400);
    chk("tick_period", k, 256);
    chk("nodata_dac", dac_data, 8'h80);
    chk("nodata_und", underrun, 1'b0);

    // Priming threshold table
    foreach (tbl[i]) begin
      rst = 1'b1; en = 1'b0;
      cyc(1);
      rst = 1'b0; en = 1'b1;
      cyc(1);
      for (int j = 0; j < tbl[i].n; j++) push1(8'(17 * (j + 1)), 1'b0);
      chk($sformatf("t%0d_lvl_pre", i), fifo_level, tbl[i].lvl_pre);
      chk($sformatf("t%0d_rdy_pre", i), in_ready, tbl[i].rdy_pre);
      wait_tick(300);
      cyc(1);
      chk($sformatf("t%0d_dac", i), dac_data, tbl[i].dac);
      chk($sformatf("t%0d_lvl", i), fifo_level, tbl[i].lvl);
      chk($sformatf("t%0d_rdy", i), in_ready, tbl[i].rdy);
      chk($sformatf("t%0d_cnt", i), pwm_cnt, 8'h00);
    end

    // Scoreboarded playback, underrun, clear collision
    rst = 1'b1; en = 1'b0;
    cyc(1);
    rst = 1'b0; en = 1'b1;
    cyc(1);
    push1(8'h10, 1'b1);
    push1(8'h20, 1'b1);
    mon_en = 1'b1;
    wait_tick(300);
    chk("pb_rdy0", in_ready, 1'b1);
    cyc(1);
    wait_tick(300);
    chk("pb_rdy1", in_ready, 1'b1);
    cyc(1);
    chk("pb_lvl", fifo_level, 3'd0);
    chk("pb_und0", underrun, 1'b0);
    wait_tick(300);
    cyc(1);
    chk("pb_und1", underrun, 1'b1);
    clr_underrun = 1'b1;
    cyc(1);
    clr_underrun = 1'b0;
    chk("clr_und", underrun, 1'b0);
    push1(8'h33, 1'b1);
    push1(8'h44, 1'b1);
    wait_tick(300);
    cyc(1);
    chk("run_lvl1", fifo_level, 3'd1);
    wait_tick(300);
    cyc(1);
    chk("run_lvl0", fifo_level, 3'd0);
    wait_tick(300);
    clr_underrun = 1'b1;
    cyc(1);
    clr_underrun = 1'b0;
    chk("set_wins", underrun, 1'b1);
    mon_en = 1'b0;

    // Push colliding with an empty-FIFO RUN tick: no bypass
    clr_underrun = 1'b1;
    cyc(1);
    clr_underrun = 1'b0;
    push1(8'h61, 1'b0);
    push1(8'h62, 1'b0);
    wait_tick(300);
    cyc(1);
    chk("nb_dac61", dac_data, 8'h61);
    wait_tick(300);
    cyc(1);
    chk("nb_dac62", dac_data, 8'h62);
    wait_tick(300);
    push1(8'h55, 1'b0);
    chk("nb_und", underrun, 1'b1);
    chk("nb_lvl", fifo_level, 3'd1);
    chk("nb_dac", dac_data, 8'h80);

    // Enable drop mid-period keeps underrun
    push1(8'h71, 1'b0);
    push1(8'h72, 1'b0);
    cyc(5);
    chk("en_lvl3", fifo_level, 3'd3);
    en = 1'b0;
    cyc(1);
    chk("en_lvl", fifo_level, 3'd0);
    chk("en_cnt", pwm_cnt, 8'h00);
    chk("en_dac", dac_data, 8'h80);
    chk("en_rdy", in_ready, 1'b0);
    chk("en_tick", frame_tick, 1'b0);
    chk("en_und", underrun, 1'b1);

    // Asynchronous reset mid-period with a push pending
    en = 1'b1;
    cyc(1);
    push1(8'h01, 1'b0);
    push1(8'h02, 1'b0);
    cyc(10);
    in_valid = 1'b1;
    in_data  = 8'h99;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_lvl", fifo_level, 3'd0);
    chk("ar_cnt", pwm_cnt, 8'h00);
    chk("ar_dac", dac_data, 8'h80);
    chk("ar_und", underrun, 1'b0);
    chk("ar_rdy", in_ready, 1'b0);
    chk("ar_tick", frame_tick, 1'b0);
    in_valid = 1'b0;
    cyc(1);
    rst = 1'b0;
    chk("ar_lvl_hold", fifo_level, 3'd0);
    cyc(1);
    chk("ar_prime_cnt", pwm_cnt, 8'h00);
    chk("ar_prime_lvl", fifo_level, 3'd0);
    cyc(1);
    chk("ar_run_cnt", pwm_cnt, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_dac_ctrl.md
PWM_DAC_CTRL -- requirements
Module: pwm_dac_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: sample width and PWM period counter width; period is 2^WIDTH clocks.
REQ-002 Parameter DEPTH, default 4: sample FIFO depth; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run enable; 0 forces IDLE.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_data  input  WIDTH  upstream sample, unsigned.
REQ-008 in_ready  output  1  FIFO can accept a sample this cycle.
REQ-009 clr_underrun  input  1  synchronous clear of underrun flag.
REQ-010 dac_data  output  WIDTH  registered sample presented to the PWM comparator.
REQ-011 pwm_cnt  output  WIDTH  registered period counter shared with the comparator.
REQ-012 frame_tick  output  1  one-cycle pulse marking the last cycle of a PWM period.
REQ-013 underrun  output  1  sticky underrun flag.
REQ-014 fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-015 Push SHALL occur when in_valid and in_ready are both 1; in_ready SHALL equal (fifo_level != DEPTH), combinational from registered level only.
REQ-016 FIFO SHALL be first-in first-out, with no bypass: a sample pushed in cycle N is poppable from cycle N+1 onward.
REQ-017 Simultaneous push and pop SHALL leave fifo_level unchanged and both operations SHALL take effect.
REQ-018 States SHALL be IDLE, PRIME, RUN; MID denotes 2^(WIDTH-1) (0x80 for WIDTH=8).
REQ-019 IDLE: pwm_cnt held 0, frame_tick 0, dac_data = MID, FIFO flushed (level 0), in_ready 0; en=1 SHALL move to PRIME on the next edge.
REQ-020 PRIME/RUN: pwm_cnt SHALL increment by 1 each cycle, wrapping from all-ones to 0.
REQ-021 frame_tick SHALL be 1 exactly in cycles where state is PRIME or RUN and pwm_cnt is all-ones.
REQ-022 PRIME: on a frame_tick cycle with fifo_level >= DEPTH/2, SHALL pop the head into dac_data and go to RUN; otherwise dac_data stays MID.
REQ-023 RUN: on a frame_tick cycle with fifo_level >= 1, SHALL pop the head into dac_data and stay in RUN.
REQ-024 RUN: on a frame_tick cycle with fifo_level = 0, SHALL load dac_data = MID, set underrun, and go to PRIME.
REQ-025 dac_data SHALL change only at the edge ending a frame_tick cycle, i.e. coincident with pwm_cnt wrapping to 0; latency from pop decision to dac_data is one edge.
REQ-026 underrun SHALL set only per REQ-024; clr_underrun SHALL clear it; set SHALL win when both occur in the same cycle.
REQ-027 en=0 in any state SHALL move to IDLE on the next edge, flush the FIFO, and discard any pop that cycle; underrun SHALL be preserved.
REQ-028 A push offered in a cycle where en=0 SHALL be ignored.

Reset
REQ-029 While rst=1: state IDLE, pwm_cnt 0, dac_data MID, frame_tick 0, underrun 0, fifo_level 0, in_ready 0, FIFO pointers 0.
REQ-030 Reset asserted mid-period or mid-push SHALL take effect immediately, and the pending push SHALL be lost; after rst falls, operation per REQ-019.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Reset then en=1, no data -> dac_data stays 0x80, frame_tick every 256 cycles with pwm_cnt=0xFF, underrun stays 0.
REQ-032 Push 0x10, 0x20 during the first period -> 0x10 appears at the first wrap, 0x20 at the second; RUN; in_ready stays 1.
REQ-033 Push 4 samples with no tick -> fifo_level 4, in_ready 0, a 5th in_valid is not accepted; the tick pops, giving level 3 and in_ready 1.
REQ-034 RUN with level 1, no further pushes -> the next tick pops, and the following tick loads 0x80, sets underrun, and enters PRIME; clr_underrun and an underrun event in the same cycle leave underrun=1.
REQ-035 Push when the FIFO is empty in the same cycle as a RUN tick -> underrun occurs (no bypass); fifo_level becomes 1.
REQ-036 en dropped mid-period with level 3 -> next cycle IDLE, level 0, pwm_cnt 0, dac_data 0x80; an asynchronous rst pulse mid-period gives the same, with underrun cleared.
